// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and entry type for the write-back link queue
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_REG_AW = 5;

  localparam logic [5:0] WB_LINK_OPC = 6'b010001;
  localparam int         WB_LINK_REG = 31;

  typedef struct packed {
    logic [WB_REG_AW-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - generic DEPTH-entry FIFO with wrap-bit pointers and flush
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          push,
  input  logic [W-1:0]                  push_data,
  input  logic                          pop,
  output logic [W-1:0]                  head_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic [$clog2(DEPTH)-1:0]      rd_idx,
  output logic [DEPTH-1:0][W-1:0]       entries
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]             wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

  // Pointers differ only in the wrap bit when every slot is occupied.
  assign empty     = (wr_q == rd_q);
  assign full      = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});
  assign count     = wr_q - rd_q;
  assign rd_idx    = rd_q[AW-1:0];
  assign head_data = mem_q[rd_q[AW-1:0]];
  assign entries   = mem_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_q[AW-1:0]] = push_data;
        wr_d = wr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_d = rd_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/wb_link_queue.sv
// rtl/wb_link_queue.sv - resolves write-back requests, queues them and drains to the register file
module wb_link_queue
  import wb_pkg::*;
#(
  parameter int               DATA_W    = 32,
  parameter int               REG_AW    = 5,
  parameter int               OPC_W     = 6,
  parameter logic [OPC_W-1:0] LINK_OPC  = WB_LINK_OPC,
  parameter int               LINK_REG  = WB_LINK_REG,
  parameter int               DEPTH     = 2,
  parameter bit               ZERO_DROP = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       reg_write,
  input  logic [OPC_W-1:0]           opcode,
  input  logic [DATA_W-1:0]          next_pc,
  input  logic [REG_AW-1:0]          write_reg,
  input  logic [DATA_W-1:0]          write_data,
  output logic                       rf_we,
  output logic [REG_AW-1:0]          rf_addr,
  output logic [DATA_W-1:0]          rf_data,
  input  logic                       rf_ready,
  input  logic [REG_AW-1:0]          look_addr,
  output logic                       look_hit,
  output logic [DATA_W-1:0]          look_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = REG_AW + DATA_W;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic                    full, empty, accept, discard, push, pop, drop_inc;
  logic [AW-1:0]           rd_idx;
  logic [EW-1:0]           head_raw;
  logic [DEPTH-1:0][EW-1:0] entries;
  entry_t                  resolved, head;
  entry_t                  last_q, last_d;
  logic [15:0]             drop_q, drop_d;

  assign in_ready = rst_n && !full;
  assign accept   = in_valid && in_ready;

  always_comb begin
    resolved.addr = write_reg;
    resolved.data = write_data;
    if (opcode == LINK_OPC) begin
      resolved.addr = REG_AW'(LINK_REG);
      resolved.data = next_pc;
    end
  end

  assign discard  = !reg_write || (ZERO_DROP && (resolved.addr == '0));
  assign push     = accept && !discard && !flush;
  assign drop_inc = accept && discard && !flush;
  assign pop      = !empty && rf_ready;

  wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (resolved),
    .pop       (pop),
    .head_data (head_raw),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .rd_idx    (rd_idx),
    .entries   (entries)
  );

  assign head    = entry_t'(head_raw);
  assign rf_we   = !empty;
  assign rf_addr = empty ? last_q.addr : head.addr;
  assign rf_data = empty ? last_q.data : head.data;

  // Remember whatever the port last showed so an empty queue keeps it stable.
  always_comb begin
    last_d = empty ? last_q : head;
    drop_d = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  assign drop_cnt = drop_q;

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [AW-1:0] idx;
    entry_t        e;
    look_hit  = 1'b0;
    look_data = '0;
    idx       = '0;
    e         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_idx + AW'(i);
      e   = entry_t'(entries[idx]);
      if (((AW+1)'(i) < count) && (e.addr == look_addr) &&
          !(ZERO_DROP && (look_addr == '0))) begin
        look_hit  = 1'b1;
        look_data = e.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      drop_q <= '0;
    end else begin
      last_q <= last_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: doc/wb_link_queue.md
Name: wb_link_queue

Overview:
- Parametrised write-back unit between the multicycle datapath and the register-file write port.
- Resolves the destination register and write data for each write-back request. Link opcodes force LINK_REG and next_pc; all others pass write_reg and write_data through.
- Buffers resolved writes in a DEPTH-entry FIFO and drains one per cycle when the register file is ready.
- Exposes a pending-write lookup so the control unit can forward data or stall on a queued result.

Parameters:
- DATA_W, 32, data and PC width
- REG_AW, 5, register address width
- OPC_W, 6, opcode width
- LINK_OPC, 6'b010001, opcode treated as jump-and-link
- LINK_REG, 31, link destination register
- DEPTH, 2, FIFO entries (power of two, >=2)
- ZERO_DROP, 1, 1 = writes to register 0 are discarded

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of the queue
- in_valid  in  1  write-back request present
- in_ready  out  1  request can be accepted this cycle
- reg_write  in  1  RegWrite from control unit
- opcode  in  OPC_W  instruction opcode
- next_pc  in  DATA_W  PC+4 of the instruction
- write_reg  in  REG_AW  normal destination
- write_data  in  DATA_W  normal result
- rf_we  out  1  register-file write strobe
- rf_addr  out  REG_AW  write address
- rf_data  out  DATA_W  write data
- rf_ready  in  1  register file accepts the write this cycle
- look_addr  in  REG_AW  lookup address
- look_hit  out  1  look_addr pending in queue
- look_data  out  DATA_W  data of youngest matching entry
- count  out  clog2(DEPTH)+1  occupancy
- drop_cnt  out  16  saturating count of discarded requests

Behaviour:
- Reset (rst_n low, asynchronous):
  - queue empty; count=0, drop_cnt=0
  - rf_we=0, rf_addr=0, rf_data=0
  - look_hit=0, look_data=0
  - in_ready=0 while reset is asserted.
- in_ready = !full; it is registered-state only, with no combinational path from rf_ready.
- Acceptance: a request is accepted when in_valid && in_ready at the clk edge.
- Resolution of an accepted request:
  - reg_write=0 -> discarded.
  - opcode==LINK_OPC -> dest=LINK_REG, data=next_pc.
  - otherwise -> dest=write_reg, data=write_data.
  - ZERO_DROP=1 and dest==0 -> discarded.
  - Each discarded request increments drop_cnt, which saturates at 16'hFFFF.
- Non-discarded requests are enqueued at the tail.
- Output is the head entry:
  - rf_we=!empty; rf_addr and rf_data show the head entry.
  - When empty, rf_addr and rf_data hold their last values.
  - Head is dequeued at an edge where rf_we && rf_ready.
- Latency: a request accepted into an empty queue appears on rf_we at the next cycle. Minimum latency is 1 clock; there is no same-cycle bypass.
- Simultaneous enqueue and dequeue:
  - Allowed at any occupancy below full; count is unchanged.
  - When full, in_ready=0, so no enqueue occurs even if a dequeue happens that cycle.
- Wrap-around: read and write pointers are clog2(DEPTH) bits plus a wrap bit. full = pointers equal except the wrap bit.
- Lookup (combinational on queue contents):
  - look_hit is set if any valid entry has addr==look_addr. The youngest match supplies look_data.
  - look_addr==0 never hits when ZERO_DROP=1.
  - An entry dequeuing this cycle still counts as a hit.
- flush:
  - Empties the queue at the next edge; queued writes are lost; drop_cnt is not incremented.
  - Any input accepted in the same cycle is also discarded.
  - flush has priority over enqueue and dequeue.
- Reset mid-drain: queue contents are lost and rf_we falls immediately (asynchronous).
- Widths: data fields are DATA_W wide throughout. next_pc is not truncated.

Decomposition:
- Shared package wb_pkg holds:
  - default LINK_OPC and LINK_REG constants
  - a typedef wb_entry_t {addr[REG_AW], data[DATA_W]}
- One natural sub-module, wb_fifo: generic DEPTH x entry FIFO with pointers, full/empty, count, and flush.
- The top level holds resolution, drop counting and the lookup compare.

Test Plan:
1. Reset, then reg_write=1, opcode=6'b010001, next_pc=32'h0000_0044, write_reg=5 -> one cycle later rf_we=1, rf_addr=31, rf_data=32'h44.
2. opcode=6'b000000, write_reg=7, write_data=32'hDEAD_BEEF, rf_ready=1 -> rf_we=1, rf_addr=7, rf_data=32'hDEADBEEF for exactly one cycle; count goes 1 then 0.
3. rf_ready=0 with three requests to regs 3, 4, 5 (DEPTH=2) -> in_ready drops after two; count=2. Raise rf_ready -> writes to 3, 4, 5 appear in order, with no loss and no duplication.
4. Requests with reg_write=0, and with write_reg=0 -> no rf_we; drop_cnt=2.
5. Queue holds reg 9=32'h1 (older) and reg 9=32'h2 (younger); look_addr=9 -> look_hit=1, look_data=32'h2.
6. Queue full, assert flush with in_valid=1 -> next cycle count=0, rf_we=0, drop_cnt unchanged. Separately, drop rst_n low mid-drain -> rf_we=0 immediately.
